// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command path: frame delimiters, framer FSM encoding, parser ctrl codes.
package uart_cmd_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h55;
  localparam logic [7:0] EOF_DEFAULT = 8'hAA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_CMD = 2'd1,
    GET_CHK = 2'd2,
    GET_EOF = 2'd3
  } frame_state_t;

  // Ctrl-nibble codes understood by the command parser.
  localparam logic [3:0] CTRL_MOVE  = 4'h0;
  localparam logic [3:0] CTRL_SPLIT = 4'h1;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, strobes tc combinationally at TIMEOUT_CYCLES-1.
// No flow control; tc is suppressed on any cycle where clr is asserted so a byte always beats the timeout.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && !clr && (cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_command_frame.sv
// Framer for SOF/CMD/CHK/EOF command frames from uart_rx; flag and error pulses are registered one cycle after the deciding byte.
// No back-pressure: one byte per cycle is always accepted; stalled frames are dropped by the inter-byte timeout.
module uart_command_frame
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = uart_cmd_pkg::SOF_DEFAULT,
  parameter logic [7:0] EOF_BYTE       = uart_cmd_pkg::EOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I_rx_valid,
  input  logic [7:0] I_rx_data,
  output logic       O_command_flag,
  output logic [3:0] O_ctrl_command,
  output logic [3:0] O_value_command,
  output logic       O_frame_err,
  output logic [7:0] O_err_cnt
);

  frame_state_t state, state_nxt;
  logic [7:0]   cmd_q, cmd_nxt;
  logic         flag_nxt, err_nxt;
  logic         tmo;

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (I_rx_valid || (state == IDLE)),
    .en   (state != IDLE),
    .tc   (tmo)
  );

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    flag_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (tmo) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end else if (I_rx_valid) begin
      case (state)
        IDLE: begin
          if (I_rx_data == SOF_BYTE) state_nxt = GET_CMD;
        end
        GET_CMD: begin
          cmd_nxt   = I_rx_data;
          state_nxt = GET_CHK;
        end
        GET_CHK: begin
          if (I_rx_data == (SOF_BYTE ^ cmd_q)) begin
            state_nxt = GET_EOF;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        GET_EOF: begin
          if (I_rx_data == EOF_BYTE) begin
            flag_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            // A stray SOF in the EOF slot is most likely the start of the next frame.
            err_nxt   = 1'b1;
            state_nxt = (I_rx_data == SOF_BYTE) ? GET_CMD : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cmd_q           <= '0;
      O_command_flag  <= 1'b0;
      O_frame_err     <= 1'b0;
      O_ctrl_command  <= '0;
      O_value_command <= '0;
      O_err_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      cmd_q          <= cmd_nxt;
      O_command_flag <= flag_nxt;
      O_frame_err    <= err_nxt;
      if (flag_nxt) begin
        O_ctrl_command  <= cmd_q[7:4];
        O_value_command <= cmd_q[3:0];
      end
      if (err_nxt && (O_err_cnt != 8'hFF)) O_err_cnt <= O_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_command_frame.sv
// Directed bench for uart_command_frame; expected flag/error events are queued with their due cycle and matched by a monitor.
module tb_uart_command_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       command_flag;
  logic [3:0] ctrl_command;
  logic [3:0] value_command;
  logic       frame_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         is_flag;
    logic [3:0] ctrl;
    logic [3:0] value;
    int         due;
  } ev_t;

  ev_t exp_q[$];

  uart_command_frame #(
    .TIMEOUT_CYCLES(100),
    .CNT_W         (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .I_rx_valid     (rx_valid),
    .I_rx_data      (rx_data),
    .O_command_flag (command_flag),
    .O_ctrl_command (ctrl_command),
    .O_value_command(value_command),
    .O_frame_err    (frame_err),
    .O_err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 no event, 1 flag with ctrl/value, 2 frame error; dly is cycles from drive to visible pulse.
  task automatic send(input logic [7:0] b, input int kind = 0, input logic [3:0] c = 4'h0,
                      input logic [3:0] v = 4'h0, input int dly = 1);
    ev_t e;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (kind != 0) begin
      e.is_flag = (kind == 1);
      e.ctrl    = c;
      e.value   = v;
      e.due     = cyc + dly;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] c, input logic [3:0] v,
                             input logic [7:0] ec);
    chk({tag, "_ctrl"}, 32'(ctrl_command), 32'(c));
    chk({tag, "_value"}, 32'(value_command), 32'(v));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (command_flag || frame_err)) begin
      chk("flag_err_exclusive", 32'(command_flag && frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event_flag", 32'(command_flag), 32'd0);
        chk("unexpected_event_err", 32'(frame_err), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_flag", 32'(command_flag), 32'(e.is_flag));
        chk("event_cycle", 32'(cyc), 32'(e.due));
        if (e.is_flag) begin
          chk("event_ctrl", 32'(ctrl_command), 32'(e.ctrl));
          chk("event_value", 32'(value_command), 32'(e.value));
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_flag", 32'(command_flag), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk_outputs("rst", 4'h0, 4'h0, 8'h00);

    // 1: two valid frames separated by idle time
    send(8'h55); send(8'h10); send(8'h45); send(8'hAA, 1, 4'h1, 4'h0);
    idle(10);
    send(8'h55); send(8'h13); send(8'h46); send(8'hAA, 1, 4'h1, 4'h3);
    idle(3);
    chk_outputs("t1", 4'h1, 4'h3, 8'h00);

    // 2: bad checksum, trailing EOF dropped in IDLE
    send(8'h55); send(8'h01); send(8'h00, 2); send(8'hAA);
    idle(3);
    chk_outputs("t2", 4'h1, 4'h3, 8'h01);

    // 3: SOF in EOF slot resyncs onto the next frame
    do_reset();
    send(8'h55); send(8'h01); send(8'h54); send(8'h55, 2);
    send(8'h01); send(8'h54); send(8'hAA, 1, 4'h0, 4'h1);
    idle(3);
    chk_outputs("t3", 4'h0, 4'h1, 8'h01);

    // 4: stall mid-frame times out after 100 idle cycles; late bytes dropped
    do_reset();
    send(8'h55); send(8'h11, 2, 4'h0, 4'h0, 101);
    idle(100);
    send(8'h44); send(8'hAA);
    idle(3);
    chk_outputs("t4_tmo", 4'h0, 4'h0, 8'h01);
    send(8'h55); send(8'h11); send(8'h44); send(8'hAA, 1, 4'h1, 4'h1);
    idle(3);
    chk_outputs("t4", 4'h1, 4'h1, 8'h01);

    // 5: reset mid-frame discards the partial frame and clears held outputs
    send(8'h55); send(8'h12);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_outputs("t5_async", 4'h0, 4'h0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h57); send(8'hAA);
    idle(5);
    chk("t5_flag", 32'(command_flag), 32'd0);
    chk("t5_err", 32'(frame_err), 32'd0);
    chk_outputs("t5", 4'h0, 4'h0, 8'h00);

    // 6: error counter saturation, then back-to-back valid frames
    for (int i = 0; i < 300; i++) begin
      send(8'h55); send(8'h00); send(8'h00, 2); send(8'hAA);
    end
    idle(3);
    chk_outputs("t6_sat", 4'h0, 4'h0, 8'hFF);
    send(8'h55); send(8'h14); send(8'h41); send(8'hAA, 1, 4'h1, 4'h4);
    send(8'h55); send(8'h14); send(8'h41); send(8'hAA, 1, 4'h1, 4'h4);
    idle(3);
    chk_outputs("t6", 4'h1, 4'h4, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
